// File: rtl/rf_pkg.sv
// rf_pkg -- shared constants and helpers for the reg_file_sb register file.
//   RF_WIDTH_DEF / RF_DEPTH_DEF : default data width and register count.
//   RF_RST_VAL(index, width)    : reset value of register `index`
//                                 (0 for index 0, otherwise 1 << (index-1),
//                                 truncated to `width` bits).
package rf_pkg;

  localparam int RF_WIDTH_DEF = 8;
  localparam int RF_DEPTH_DEF = 4;

  // Returned 64 bits wide; callers cut it down to their data width.
  // A shift past the data width leaves zero, which is the truncated value.
  function automatic logic [63:0] RF_RST_VAL(input int index, input int width);
    logic [63:0] v;
    v = '0;
    if ((index > 0) && ((index - 1) < width) && ((index - 1) < 64)) begin
      v = 64'd1 << (index - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port -- one read port of reg_file_sb.
//   Selects register rd_addr out of the flattened register array, optionally
//   forwards the same-cycle write data, flags a scoreboard hit and registers
//   the selected data when the top-level read is accepted.
//   Optional feature macro: REG_FILE_SB_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, Reset      clock, synchronous active-high reset
//   rd_en, rd_addr  read request for this port
//   accept          whole-read accept from the top (no stall on either port)
//   regs, busy      current register contents and scoreboard
//   wr_en/addr/data same-cycle write, used only for forwarding
//   hit             this port's request targets a busy, non-forwarded register
//   rd_data         registered read data, held when not loaded
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  input  logic                         accept,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]             busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         hit,
  output logic [WIDTH-1:0]             rd_data
);

  logic             fwd;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] rd_data_reg;

`ifdef REG_FILE_SB_BYPASS_EN
  // A write landing on the register being read satisfies the read directly,
  // so the pending scoreboard entry does not need to stall it.
  assign fwd      = wr_en & (wr_addr == rd_addr);
  assign sel_data = fwd ? wr_data : regs[rd_addr];
`else
  // No forwarding path: same-cycle reads see the old contents.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign fwd       = 1'b0;
  assign sel_data  = regs[rd_addr];
`endif

  assign hit = rd_en & busy[rd_addr] & ~fwd;

  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_data_reg <= '0;
    end else if (accept && rd_en) begin
      rd_data_reg <= sel_data;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb -- small register file with a busy scoreboard and two read ports.
//   Registers reset to RF_RST_VAL(i). IssueEn marks a register busy, a write
//   clears it (issue wins on a same-index collision). A read that hits a busy
//   register raises Stall combinationally and is dropped; the requester must
//   re-present it. Accepted reads return data one cycle later with RdValid.
//   Optional feature macro: REG_FILE_SB_BYPASS_EN -- forward same-cycle write
//   data to a matching read and suppress its stall.
// Ports:
//   clk, Reset                      clock, synchronous active-high reset
//   WrEn, WrAddr, WrData            write port
//   IssueEn, IssueAddr              scoreboard set
//   RdEnA/B, RdAddrA/B              read requests
//   RdDataA/B, RdValid              registered read results
//   Busy                            scoreboard, one bit per register
//   Stall                           combinational read-hits-busy flag
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             IssueEn,
  input  logic [AW-1:0]    IssueAddr,
  input  logic             RdEnA,
  input  logic             RdEnB,
  input  logic [AW-1:0]    RdAddrA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB,
  output logic             RdValid,
  output logic [DEPTH-1:0] Busy,
  output logic             Stall
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_flat;
  logic [DEPTH-1:0]            busy_reg;
  logic [DEPTH-1:0]            busy_next;
  logic                        rd_valid_reg;
  logic                        hit_a;
  logic                        hit_b;
  logic                        accept;

  // One storage element per register so each carries its own reset value.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RF_RST_VAL(gi, WIDTH));
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (Reset) begin
          q_reg <= RST_VAL;
        end else if (WrEn && (WrAddr == AW'(gi))) begin
          q_reg <= WrData;
        end
      end

      assign regs_flat[gi] = q_reg;
    end
  endgenerate

  // Clear first, then set, so a same-index issue overrides the write's clear.
  always_comb begin
    busy_next = busy_reg;
    if (WrEn) begin
      busy_next[WrAddr] = 1'b0;
    end
    if (IssueEn) begin
      busy_next[IssueAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // A stall on either port drops the whole read; nothing is half-accepted.
  assign Stall  = hit_a | hit_b;
  assign accept = (RdEnA | RdEnB) & ~Stall;

  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= accept;
    end
  end

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_a (
    .clk     (clk),
    .Reset   (Reset),
    .rd_en   (RdEnA),
    .rd_addr (RdAddrA),
    .accept  (accept),
    .regs    (regs_flat),
    .busy    (busy_reg),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .hit     (hit_a),
    .rd_data (RdDataA)
  );

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_b (
    .clk     (clk),
    .Reset   (Reset),
    .rd_en   (RdEnB),
    .rd_addr (RdAddrB),
    .accept  (accept),
    .regs    (regs_flat),
    .busy    (busy_reg),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .hit     (hit_b),
    .rd_data (RdDataB)
  );

  assign RdValid = rd_valid_reg;
  assign Busy    = busy_reg;

endmodule
